reg_dump_reader: RTL

REG_DUMP_READER -- requirements
Module: reg_dump_reader

---
 rtl/reg_dump_pkg.sv | 11 +
 rtl/reg_dump_reader.sv | 91 +++++++++
 2 files changed

// File: rtl/reg_dump_pkg.sv
// reg_dump_pkg: FSM state encoding and default widths shared by the register dump reader
package reg_dump_pkg;
  localparam int unsigned DATA_WIDTH_DEF = 32;
  localparam int unsigned ADDR_WIDTH_DEF = 5;
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    SEND = 2'd2,
    DONE = 2'd3
  } state_e;
endpackage

// File: rtl/reg_dump_reader.sv
// reg_dump_reader: streams every register of a register file read port out as valid/ready words; optional REG_DUMP_PARITY_EN adds out_parity
module reg_dump_reader
  import reg_dump_pkg::*;
#(
  parameter int unsigned data_width = DATA_WIDTH_DEF,
  parameter int unsigned addr_width = ADDR_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  output logic [addr_width-1:0] rd_addr,
  input  logic [data_width-1:0] rd_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [data_width-1:0] out_data,
  output logic [addr_width-1:0] out_addr,
  output logic                  out_last,
  output logic                  busy,
`ifdef REG_DUMP_PARITY_EN
  output logic                  out_parity,
`endif
  output logic                  done
);
  localparam logic [addr_width-1:0] LAST_ADDR = '1;
  state_e state_q, state_d;
  logic [addr_width-1:0] cnt_q, cnt_d;
  logic [addr_width-1:0] addr_q, addr_d;
  logic [data_width-1:0] data_q, data_d;
  // next state, counter and capture registers; the counter stops at the last address and is cleared on the way back to IDLE
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    data_d  = data_q;
    case (state_q)
      IDLE: if (start) begin
        state_d = READ;
        cnt_d   = '0;
      end
      READ: begin
        data_d  = rd_data;
        addr_d  = cnt_q;
        state_d = SEND;
      end
      SEND: if (out_ready) begin
        if (cnt_q == LAST_ADDR) state_d = DONE;
        else begin
          cnt_d   = cnt_q + addr_width'(1);
          state_d = READ;
        end
      end
      DONE: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
      default: state_d = IDLE;
    endcase
  end
  // state and captured word, cleared asynchronously so outputs drop to zero at once
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
    end
  end
  assign rd_addr   = cnt_q;
  assign out_valid = state_q == SEND;
  assign out_data  = data_q;
  assign out_addr  = addr_q;
  assign out_last  = (state_q == SEND) && (addr_q == LAST_ADDR);
  assign busy      = (state_q == READ) || (state_q == SEND);
  assign done      = state_q == DONE;
`ifdef REG_DUMP_PARITY_EN
  logic par_q, par_d;
  // parity is captured with the data word so both stay stable together under backpressure
  always_comb par_d = (state_q == READ) ? ^rd_data : par_q;
  // parity register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) par_q <= 1'b0;
    else        par_q <= par_d;
  end
  assign out_parity = par_q;
`endif
endmodule
